// File: rtl/huff_enc_sequencer_if.sv
// Job and result handshake bundle between a host and the Huffman encoder sequencer.
// The host side uses the master modport; the sequencer uses the slave modport.
interface huff_enc_sequencer_if;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_sym;
  logic [8:0]  job_freq;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_value;
  logic [8:0]  res_mask;
  logic        res_err;

  modport master (
    output job_valid, job_sym, job_freq, res_ready,
    input  job_ready, res_valid, res_value, res_mask, res_err
  );

  modport slave (
    input  job_valid, job_sym, job_freq, res_ready,
    output job_ready, res_valid, res_value, res_mask, res_err
  );
endinterface

// File: rtl/huff_enc_sequencer.sv
// Job-level sequencer for the 12-bit-io Huffman encoder core: reset core, load 3 symbols,
// wait for done, capture the {mask,value} words, and return them as a single result beat.
//
// state     | meaning
// IDLE      | job_ready high, waiting for a job handshake
// ENC_RST   | one-cycle enc_reset pulse to clear the core load counter and sticky done
// LOAD      | drive {1, freq, sym} for symbols 0..2, one per cycle
// WAIT_DONE | wait for done; abort with res_err when the timeout counter expires
// CAPTURE   | collect header/data words 1..6; done dropping aborts with res_err
// RESP      | hold the result until res_ready, then park the core and return to IDLE
module huff_enc_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  huff_enc_sequencer_if.slave   bus,
  output logic                  busy,
  output logic                  enc_reset,
  output logic [11:0]           enc_io_in,
  input  logic [11:0]           enc_io_out
);

  typedef enum logic [2:0] {IDLE, ENC_RST, LOAD, WAIT_DONE, CAPTURE, RESP} state_t;

  state_t          state;
  logic [23:0]     sym_q;
  logic [8:0]      freq_q;
  logic [1:0]      idx;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      wcnt;
  logic [2:0]      word_k;
  logic            done;
  logic            unused_io;

  assign done      = enc_io_out[8];
  assign word_k    = wcnt + 3'd1;
  assign unused_io = ^{enc_io_out[11:9], enc_io_out[7:6]};

  function automatic logic [11:0] load_word(input logic [1:0] i, input logic [23:0] s,
                                            input logic [8:0] f);
    case (i)
      2'd0:    return {1'b1, f[8:6], s[23:16]};
      2'd1:    return {1'b1, f[5:3], s[15:8]};
      default: return {1'b1, f[2:0], s[7:0]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.job_ready <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_value <= '0;
      bus.res_mask  <= '0;
      bus.res_err   <= 1'b0;
      busy          <= 1'b0;
      enc_reset     <= 1'b1;
      enc_io_in     <= '0;
      sym_q         <= '0;
      freq_q        <= '0;
      idx           <= '0;
      to_cnt        <= '0;
      wcnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          enc_reset     <= 1'b0;
          enc_io_in     <= '0;
          busy          <= 1'b0;
          bus.job_ready <= 1'b1;
          if (bus.job_valid && bus.job_ready) begin
            sym_q         <= bus.job_sym;
            freq_q        <= bus.job_freq;
            bus.job_ready <= 1'b0;
            bus.res_value <= '0;
            bus.res_mask  <= '0;
            bus.res_err   <= 1'b0;
            busy          <= 1'b1;
            enc_reset     <= 1'b1;
            state         <= ENC_RST;
          end
        end
        ENC_RST: begin
          enc_reset <= 1'b0;
          idx       <= 2'd0;
          enc_io_in <= load_word(2'd0, sym_q, freq_q);
          state     <= LOAD;
        end
        LOAD: begin
          if (idx == 2'd2) begin
            // load_flag must fall so the core's load counter stops advancing
            enc_io_in <= '0;
            to_cnt    <= '0;
            state     <= WAIT_DONE;
          end else begin
            idx       <= idx + 2'd1;
            enc_io_in <= load_word(idx + 2'd1, sym_q, freq_q);
          end
        end
        WAIT_DONE: begin
          if (done) begin
            wcnt  <= 3'd1;
            state <= CAPTURE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            bus.res_err   <= 1'b1;
            bus.res_value <= '0;
            bus.res_mask  <= '0;
            bus.res_valid <= 1'b1;
            state         <= RESP;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (!done) begin
            bus.res_err   <= 1'b1;
            bus.res_value <= '0;
            bus.res_mask  <= '0;
            bus.res_valid <= 1'b1;
            state         <= RESP;
          end else begin
            // even words carry data for symbol k/2-1; odd words are headers
            case (word_k)
              3'd2: begin
                bus.res_mask[8:6]  <= enc_io_out[5:3];
                bus.res_value[8:6] <= enc_io_out[2:0];
              end
              3'd4: begin
                bus.res_mask[5:3]  <= enc_io_out[5:3];
                bus.res_value[5:3] <= enc_io_out[2:0];
              end
              3'd6: begin
                bus.res_mask[2:0]  <= enc_io_out[5:3];
                bus.res_value[2:0] <= enc_io_out[2:0];
              end
              default: ;
            endcase
            if (word_k == 3'd6) begin
              bus.res_err   <= 1'b0;
              bus.res_valid <= 1'b1;
              state         <= RESP;
            end else begin
              wcnt <= word_k;
            end
          end
        end
        RESP: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.job_ready <= 1'b1;
            busy          <= 1'b0;
            enc_reset     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_enc_sequencer.sv
// Directed bench for huff_enc_sequencer; the encoder core is scripted word by word
// from the stimulus tasks, and each scenario task checks its own expectations.
module tb_huff_enc_sequencer;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        enc_reset;
  logic [11:0] enc_io_in;
  logic [11:0] enc_io_out;

  int total = 0;
  int bad   = 0;

  logic [11:0] ld [3];
  logic        rst_seen;
  logic        wait_to;

  huff_enc_sequencer_if bus();

  huff_enc_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .enc_reset  (enc_reset),
    .enc_io_in  (enc_io_in),
    .enc_io_out (enc_io_out)
  );

  always #5 clk = ~clk;

  // Offer a job, then record the ENC_RST cycle and the three LOAD words.
  // Returns at the negedge of the first WAIT_DONE cycle.
  task automatic send_job(input logic [23:0] s, input logic [8:0] f);
    wait_to       = 1'b1;
    bus.job_sym   = s;
    bus.job_freq  = f;
    bus.job_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (bus.job_ready) begin
        wait_to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.job_valid = 1'b0;
    rst_seen = enc_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld[i] = enc_io_in;
    end
    @(negedge clk);
  endtask

  // Scripted core: header/data words with done=1, optional junk 7th word, then idle or sticky done.
  task automatic core_emit(input logic [8:0] m, input logic [8:0] v, input int nwords,
                           input logic stick);
    for (int k = 1; k <= nwords; k++) begin
      if (k > 6) enc_io_out = 12'h13F;
      else if (k % 2 == 1) enc_io_out = 12'h100;
      else begin
        int i;
        i = k / 2 - 1;
        enc_io_out = {3'b000, 1'b1, 2'b00, m[(2-i)*3 +: 3], v[(2-i)*3 +: 3]};
      end
      @(negedge clk);
    end
    enc_io_out = stick ? 12'h100 : 12'h000;
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.job_ready, bus.res_valid, bus.res_err, busy, enc_reset} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00001", {bus.job_ready, bus.res_valid, bus.res_err, busy, enc_reset});
    end
    total++;
    if ({bus.res_value, bus.res_mask, enc_io_in} !== 30'd0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bus.res_value, bus.res_mask, enc_io_in});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.job_ready, enc_reset, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_idle: got %b want 100", {bus.job_ready, enc_reset, busy});
    end
  endtask

  task automatic test_basic();
    send_job({8'h41, 8'h42, 8'h43}, {3'd1, 3'd2, 3'd4});
    total++;
    if ({wait_to, rst_seen} !== 2'b01) begin
      bad++;
      $display("FAIL basic_handshake: got %b want 01", {wait_to, rst_seen});
    end
    total++;
    if ({ld[0], ld[1], ld[2]} !== {12'h941, 12'hA42, 12'hC43}) begin
      bad++;
      $display("FAIL basic_load: got %h %h %h want 941 a42 c43", ld[0], ld[1], ld[2]);
    end
    total++;
    if (enc_io_in !== 12'h000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_flag_drop: got io=%h busy=%b want io=000 busy=1", enc_io_in, busy);
    end
    repeat (2) @(negedge clk);
    core_emit(9'o331, 9'o230, 7, 1'b0);
    total++;
    if ({bus.res_valid, bus.res_err} !== 2'b10) begin
      bad++;
      $display("FAIL basic_valid: got valid=%b err=%b want 1 0", bus.res_valid, bus.res_err);
    end
    total++;
    if (bus.res_mask !== 9'o331 || bus.res_value !== 9'o230) begin
      bad++;
      $display("FAIL basic_fields: got mask=%o value=%o want 331 230", bus.res_mask, bus.res_value);
    end
    accept_result();
    total++;
    if ({bus.res_valid, enc_reset, bus.job_ready, busy} !== 4'b0110) begin
      bad++;
      $display("FAIL basic_release: got %b want 0110", {bus.res_valid, enc_reset, bus.job_ready, busy});
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b0 || enc_reset !== 1'b0) begin
        bad++;
        $display("FAIL basic_one_beat: got valid=%b enc_reset=%b want 0 0", bus.res_valid, enc_reset);
      end
    end
  endtask

  task automatic test_back_to_back();
    send_job({8'h10, 8'h20, 8'h30}, {3'd3, 3'd3, 3'd2});
    core_emit(9'o313, 9'o203, 6, 1'b1);
    total++;
    if (bus.res_mask !== 9'o313 || bus.res_value !== 9'o203 || bus.res_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: got mask=%o value=%o err=%b want 313 203 0", bus.res_mask, bus.res_value, bus.res_err);
    end
    bus.res_ready = 1'b1;
    bus.job_sym   = {8'h01, 8'h02, 8'h03};
    bus.job_freq  = {3'd0, 3'd5, 3'd1};
    bus.job_valid = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    total++;
    if ({bus.res_valid, bus.job_ready, enc_reset, enc_io_in[11]} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_idle: got %b want 0110", {bus.res_valid, bus.job_ready, enc_reset, enc_io_in[11]});
    end
    if (enc_reset) enc_io_out = 12'h000;
    @(negedge clk);
    bus.job_valid = 1'b0;
    total++;
    if ({bus.job_ready, busy, enc_reset, enc_io_in[11]} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_enc_rst: got %b want 0110", {bus.job_ready, busy, enc_reset, enc_io_in[11]});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld[i] = enc_io_in;
    end
    @(negedge clk);
    total++;
    if ({ld[0], ld[1], ld[2]} !== {12'h801, 12'hD02, 12'h903}) begin
      bad++;
      $display("FAIL b2b_load: got %h %h %h want 801 d02 903", ld[0], ld[1], ld[2]);
    end
    @(negedge clk);
    core_emit(9'o133, 9'o101, 6, 1'b0);
    total++;
    if ({bus.res_valid, bus.res_err, bus.res_mask, bus.res_value} !== {2'b10, 9'o133, 9'o101}) begin
      bad++;
      $display("FAIL b2b_second: got valid=%b err=%b mask=%o value=%o want 1 0 133 101",
               bus.res_valid, bus.res_err, bus.res_mask, bus.res_value);
    end
    accept_result();
  endtask

  task automatic test_timeout();
    int n;
    send_job({8'hAA, 8'hBB, 8'hCC}, {3'd7, 3'd7, 3'd7});
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== TIMEOUT_CYC) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT_CYC);
    end
    total++;
    if ({bus.res_valid, bus.res_err, bus.res_mask, bus.res_value} !== {2'b11, 18'd0}) begin
      bad++;
      $display("FAIL timeout_result: got valid=%b err=%b mask=%o value=%o want 1 1 0 0",
               bus.res_valid, bus.res_err, bus.res_mask, bus.res_value);
    end
    accept_result();
  endtask

  task automatic test_stall();
    send_job({8'h01, 8'h02, 8'h03}, {3'd1, 3'd1, 3'd1});
    core_emit(9'o133, 9'o023, 6, 1'b0);
    bus.job_sym   = 24'hFFFFFF;
    bus.job_freq  = 9'h1FF;
    bus.job_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.res_err, bus.res_mask, bus.res_value, bus.job_ready, busy} !==
          {2'b10, 9'o133, 9'o023, 2'b01}) begin
        bad++;
        $display("FAIL stall_hold: cycle %0d got valid=%b err=%b mask=%o value=%o ready=%b busy=%b",
                 c, bus.res_valid, bus.res_err, bus.res_mask, bus.res_value, bus.job_ready, busy);
      end
    end
    bus.job_valid = 1'b0;
    accept_result();
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.job_ready, busy, enc_io_in[11]} !== 4'b0100) begin
      bad++;
      $display("FAIL stall_release: got %b want 0100", {bus.res_valid, bus.job_ready, busy, enc_io_in[11]});
    end
  endtask

  task automatic test_reset_mid_job();
    logic seen_valid;
    wait_to       = 1'b1;
    bus.job_sym   = {8'h51, 8'h52, 8'h53};
    bus.job_freq  = {3'd2, 3'd3, 3'd4};
    bus.job_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (bus.job_ready) begin
        wait_to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.job_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (enc_io_in !== 12'hB52 || wait_to !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_load1: got io=%h wait_to=%b want b52 0", enc_io_in, wait_to);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus.job_ready, bus.res_valid, bus.res_err, busy, enc_reset, bus.res_value, bus.res_mask, enc_io_in} !==
        {5'b00001, 30'd0}) begin
      bad++;
      $display("FAIL rstmid_values: got ready=%b valid=%b err=%b busy=%b enc_reset=%b value=%o mask=%o io=%h",
               bus.job_ready, bus.res_valid, bus.res_err, busy, enc_reset, bus.res_value, bus.res_mask, enc_io_in);
    end
    seen_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.res_valid) seen_valid = 1'b1;
    end
    total++;
    if (seen_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_no_result: got seen_valid=%b ready=%b want 0 1", seen_valid, bus.job_ready);
    end
  endtask

  task automatic test_done_drop();
    send_job({8'h21, 8'h22, 8'h23}, {3'd2, 3'd2, 3'd2});
    core_emit(9'o333, 9'o123, 3, 1'b0);
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_err, bus.res_mask, bus.res_value} !== {2'b11, 18'd0}) begin
      bad++;
      $display("FAIL drop_result: got valid=%b err=%b mask=%o value=%o want 1 1 0 0",
               bus.res_valid, bus.res_err, bus.res_mask, bus.res_value);
    end
    accept_result();
    send_job({8'h31, 8'h32, 8'h33}, {3'd4, 3'd1, 3'd2});
    core_emit(9'o133, 9'o101, 6, 1'b0);
    total++;
    if ({bus.res_valid, bus.res_err, bus.res_mask, bus.res_value} !== {2'b10, 9'o133, 9'o101}) begin
      bad++;
      $display("FAIL drop_recover: got valid=%b err=%b mask=%o value=%o want 1 0 133 101",
               bus.res_valid, bus.res_err, bus.res_mask, bus.res_value);
    end
    accept_result();
  endtask

  initial begin
    reset         = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_sym   = '0;
    bus.job_freq  = '0;
    bus.res_ready = 1'b0;
    enc_io_out    = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_stall();
    test_reset_mid_job();
    test_done_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
